// File: rtl/run_replay_ctrl_if.sv
// Counter strobe/status and replay pulse handshake shared by run_replay_ctrl and its neighbours.
interface run_replay_ctrl_if;
  localparam int unsigned CNT_W = 5;

  logic             cntU;
  logic             cntD;
  logic             rst5;
  logic             down_done;
  logic [CNT_W-1:0] cnt_val;
  logic             pulse_valid;
  logic             pulse_ready;

  modport master (
    output cntU, cntD, rst5, pulse_valid,
    input  down_done, cnt_val, pulse_ready
  );

  modport slave (
    input  cntU, cntD, rst5, pulse_valid,
    output down_done, cnt_val, pulse_ready
  );
endinterface

// File: rtl/run_replay_ctrl.sv
// Measures a run of 1s on a serial input with an external 5-bit counter, then
// replays the run length as handshaked pulses while counting the counter back to zero.
module run_replay_ctrl (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  run_replay_ctrl_if.master        cnt_if,
  output logic [4:0]               len_out,
  output logic                     busy,
  output logic                     done
);
  localparam int unsigned CNT_W   = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    CAPTURE = 3'd2,
    REPLAY  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;

  // State, captured length and status flags; busy/done follow the next state so they are flop outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
    end
  end

  // Next-state and counter/handshake strobes; strobes are forced low while reset is held.
  always_comb begin
    state_d            = state_q;
    len_d              = len_q;
    cnt_if.cntU        = 1'b0;
    cnt_if.cntD        = 1'b0;
    cnt_if.rst5        = 1'b0;
    cnt_if.pulse_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        cnt_if.rst5 = 1'b1;
        state_d     = CAPTURE;
      end
      CAPTURE: begin
        if (bit_valid) begin
          if (!bit_in) begin
            len_d   = cnt_if.cnt_val;
            state_d = REPLAY;
          end else if (cnt_if.cnt_val != CNT_MAX) begin
            cnt_if.cntU = 1'b1;
          end else begin
            // Saturated: the extra 1 is dropped rather than wrapping the counter.
            len_d   = CNT_MAX;
            state_d = REPLAY;
          end
        end
      end
      REPLAY: begin
        cnt_if.pulse_valid = ~cnt_if.down_done;
        cnt_if.cntD        = cnt_if.pulse_valid & cnt_if.pulse_ready;
        if (cnt_if.down_done) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!rst) begin
      cnt_if.cntU        = 1'b0;
      cnt_if.cntD        = 1'b0;
      cnt_if.rst5        = 1'b0;
      cnt_if.pulse_valid = 1'b0;
    end
  end

  assign len_out = len_q;
endmodule

// File: tb/tb_run_replay_ctrl.sv
// Directed bench for run_replay_ctrl with a behavioural 5-bit counter and a done-triggered scoreboard.
module tb_run_replay_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       ready = 1'b1;
  logic [4:0] len_out;
  logic       busy;
  logic       done;
  logic [4:0] cnt = 5'd9;

  run_replay_ctrl_if bus ();

  run_replay_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .cnt_if    (bus),
    .len_out   (len_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Counter beside the controller; deliberately not cleared by rst.
  always @(posedge clk) begin
    if (bus.rst5)      cnt <= 5'd0;
    else if (bus.cntU) cnt <= cnt + 5'd1;
    else if (bus.cntD) cnt <= cnt - 5'd1;
  end
  assign bus.down_done   = (cnt == 5'd0);
  assign bus.cnt_val     = cnt;
  assign bus.pulse_ready = ready;

  typedef struct {
    int len;
    int ups;
    int pulses;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   mon_ups = 0;
  int   mon_acc = 0;
  logic pv_prev = 1'b0;
  logic rdy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: counts strobes and accepted pulses, scores each completed run on done.
  always @(negedge clk) begin
    if (!rst) begin
      mon_ups = 0;
      mon_acc = 0;
      pv_prev = 1'b0;
    end else begin
      if (bus.cntU | bus.cntD | bus.rst5)
        check("strobe_onehot", 32'(bus.cntU) + 32'(bus.cntD) + 32'(bus.rst5), 1);
      if (pv_prev && !rdy_prev) check("pv_hold", 32'(bus.pulse_valid), 1);
      if (bus.pulse_valid) check("cntd_accept", 32'(bus.cntD), 32'(bus.pulse_ready));
      if (bus.pulse_valid && bus.pulse_ready) mon_acc++;
      if (bus.cntU) mon_ups++;
      if (done) begin
        if (sb.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("len_out", 32'(len_out), mon_e.len);
          check("cntU_count", mon_ups, mon_e.ups);
          check("pulse_count", mon_acc, mon_e.pulses);
          check("cnt_zero", 32'(cnt), 0);
        end
        mon_ups = 0;
        mon_acc = 0;
      end
      pv_prev  = bus.pulse_valid;
      rdy_prev = bus.pulse_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v, input logic b);
    bit_valid = v;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  // Issues start, steps through CLEAR and leaves the DUT in CAPTURE.
  task automatic begin_run(input int len, input int ups, input int pulses, input bit push);
    exp_t e;
    e.len = len; e.ups = ups; e.pulses = pulses;
    if (push) sb.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 0);
  endtask

  // Called right after the hand-off edge with pulse_ready held high.
  task automatic replay_timing(input int n);
    for (int i = 0; i < n; i++) begin
      check("replay_pv", 32'(bus.pulse_valid), 1);
      tick();
    end
    check("replay_gap_pv", 32'(bus.pulse_valid), 0);
    check("replay_gap_done", 32'(done), 0);
    tick();
    check("done_pulse", 32'(done), 1);
    tick();
    check("done_width", 32'(done), 0);
    check("busy_fall", 32'(busy), 0);
  endtask

  initial begin
    logic [5:0] pat;

    // Reset state
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pv", 32'(bus.pulse_valid), 0);
    check("rst_strobes", 32'(bus.cntU | bus.cntD | bus.rst5), 0);
    check("rst_len", 32'(len_out), 0);
    rst = 1'b1;
    tick();

    // Nominal run of five
    begin_run(5, 5, 5, 1'b1);
    repeat (5) send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    check("nom_len", 32'(len_out), 5);
    replay_timing(5);

    // Backpressure on a run of three
    begin_run(3, 3, 3, 1'b1);
    repeat (3) send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    pat = 6'b101001;
    for (int i = 0; i < 6; i++) begin
      ready = pat[i];
      tick();
    end
    ready = 1'b1;
    wait_idle("bp_idle", 20);

    // Zero length
    begin_run(0, 0, 0, 1'b1);
    send_bit(1'b1, 1'b0);
    check("zero_len", 32'(len_out), 0);
    replay_timing(0);

    // Saturation with 40 ones
    begin_run(31, 31, 31, 1'b1);
    repeat (40) send_bit(1'b1, 1'b1);
    wait_idle("sat_idle", 60);
    check("sat_len_hold", 32'(len_out), 31);

    // Gapped input
    begin_run(3, 3, 3, 1'b1);
    send_bit(1'b1, 1'b1);
    repeat (4) send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    check("gap_len", 32'(len_out), 3);
    wait_idle("gap_idle", 20);

    // Reset after two of six pulses
    begin_run(6, 6, 6, 1'b0);
    repeat (6) send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    tick();
    tick();
    check("abort_acc", mon_acc, 2);
    rst = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 0);
    check("abort_pv", 32'(bus.pulse_valid), 0);
    check("abort_len", 32'(len_out), 0);
    rst = 1'b1;
    repeat (5) tick();
    check("abort_no_pulses", mon_acc, 0);
    check("cnt_after_abort", 32'(cnt), 4);

    // Fresh run after abort, with a stray start during CAPTURE
    begin_run(2, 2, 2, 1'b1);
    send_bit(1'b1, 1'b1);
    start = 1'b1;
    send_bit(1'b1, 1'b1);
    start = 1'b0;
    send_bit(1'b1, 1'b0);
    check("rerun_len", 32'(len_out), 2);
    replay_timing(2);
    repeat (4) tick();
    check("start_ignored", 32'(busy), 0);
    check("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
    $fatal(1);
  end
endmodule
